cave_input: RTL

CAVE_INPUT -- requirements
Module: cave_input

---
 rtl/cave_input_pkg.sv | 65 ++++++
 rtl/cave_input_coin_stretch.sv | 35 +++
 rtl/cave_input.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cave_input_pkg.sv
// Shared definitions for the CAVE arcade input block: scan codes, player
// bit positions, the packed player word and small combinational helpers.
package cave_input_pkg;

   // Player word, LSB first: up, down, left, right, b1, b2, b3, start, coin, pause
   typedef logic [9:0] player_t;

   localparam int BIT_UP    = 0;
   localparam int BIT_DOWN  = 1;
   localparam int BIT_LEFT  = 2;
   localparam int BIT_RIGHT = 3;
   localparam int BIT_B1    = 4;
   localparam int BIT_B2    = 5;
   localparam int BIT_B3    = 6;
   localparam int BIT_START = 7;
   localparam int BIT_COIN  = 8;
   localparam int BIT_PAUSE = 9;

   // Player 1 keys
   localparam logic [7:0] SC_P1_UP    = 8'h75;
   localparam logic [7:0] SC_P1_DOWN  = 8'h72;
   localparam logic [7:0] SC_P1_LEFT  = 8'h6B;
   localparam logic [7:0] SC_P1_RIGHT = 8'h74;
   localparam logic [7:0] SC_P1_B1    = 8'h14;
   localparam logic [7:0] SC_P1_B2    = 8'h11;
   localparam logic [7:0] SC_P1_B3    = 8'h29;
   localparam logic [7:0] SC_P1_START = 8'h16;
   localparam logic [7:0] SC_P1_COIN  = 8'h2E;
   localparam logic [7:0] SC_P1_PAUSE = 8'h4D;
   // Player 2 keys (no pause key)
   localparam logic [7:0] SC_P2_UP    = 8'h2D;
   localparam logic [7:0] SC_P2_DOWN  = 8'h2B;
   localparam logic [7:0] SC_P2_LEFT  = 8'h23;
   localparam logic [7:0] SC_P2_RIGHT = 8'h34;
   localparam logic [7:0] SC_P2_B1    = 8'h1C;
   localparam logic [7:0] SC_P2_B2    = 8'h1B;
   localparam logic [7:0] SC_P2_B3    = 8'h15;
   localparam logic [7:0] SC_P2_START = 8'h1E;
   localparam logic [7:0] SC_P2_COIN  = 8'h36;
   // Service keys
   localparam logic [7:0] SC_SERVICE1 = 8'h46;
   localparam logic [7:0] SC_SERVICE2 = 8'h45;

   // Reorder the framework joystick word (right, left, down, up, b1..b3,
   // start, coin, pause) into the player word order.
   function automatic player_t joy_to_player(input logic [9:0] j);
      return {j[9], j[8], j[7], j[6], j[5], j[4], j[0], j[1], j[2], j[3]};
   endfunction

   // Opposing directions held together cancel to neutral.
   function automatic player_t socd(input player_t r);
      player_t o;
      o = r;
      if (r[BIT_UP] && r[BIT_DOWN]) begin
         o[BIT_UP]   = 1'b0;
         o[BIT_DOWN] = 1'b0;
      end
      if (r[BIT_LEFT] && r[BIT_RIGHT]) begin
         o[BIT_LEFT]  = 1'b0;
         o[BIT_RIGHT] = 1'b0;
      end
      return o;
   endfunction

endpackage

// File: rtl/cave_input_coin_stretch.sv
// Coin pulse stretcher: holds a coin active for at least COIN_FRAMES frames
// so short pulses are never missed by a game polling once per frame.
module coin_stretch #(
   parameter int COIN_FRAMES = 3
) (
   input  logic clock,
   input  logic reset,
   input  logic coin,
   input  logic vblank_rise,
   output logic coin_out
);

   localparam logic [3:0] LOAD = 4'(COIN_FRAMES);

   logic       coin_q;
   logic [3:0] count;

   // Coin edge history and frame countdown; a new coin edge wins over a frame tick.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         coin_q <= 1'b0;
         count  <= 4'd0;
      end else begin
         coin_q <= coin;
         if (coin && !coin_q)
            count <= LOAD;
         else if (vblank_rise && count != 4'd0)
            count <= count - 4'd1;
      end
   end

   assign coin_out = coin | (count != 4'd0);

endmodule

// File: rtl/cave_input.sv
// CAVE input mapper: merges PS/2 keyboard and two joysticks into two player
// words plus service buttons, with SOCD cleaning and coin stretching.
module cave_input
   import cave_input_pkg::*;
#(
   parameter int COIN_FRAMES = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [10:0] ps2_key,
   input  logic [31:0] joystick_0,
   input  logic [31:0] joystick_1,
   input  logic        vblank,
   output player_t     p1,
   output player_t     p2,
   output logic        service1,
   output logic        service2
);

   logic    toggle_q;
   logic    vblank_q;
   player_t key_p1;
   player_t key_p2;
   logic    key_svc1;
   logic    key_svc2;
   player_t raw_p1;
   player_t raw_p2;
   player_t cooked_p1;
   player_t cooked_p2;
   logic    vblank_rise;
   logic    coin_p1;
   logic    coin_p2;
   logic    unused_inputs;

   // Key event decode: a change on the toggle bit delivers one make/break event.
   always_ff @(posedge clock) begin
      // Toggle history tracks the input even in reset so leaving reset is not an event.
      toggle_q <= ps2_key[10];
      if (reset) begin
         key_p1   <= '0;
         key_p2   <= '0;
         key_svc1 <= 1'b0;
         key_svc2 <= 1'b0;
      end else if (ps2_key[10] != toggle_q) begin
         case (ps2_key[7:0])
            SC_P1_UP:    key_p1[BIT_UP]    <= ps2_key[9];
            SC_P1_DOWN:  key_p1[BIT_DOWN]  <= ps2_key[9];
            SC_P1_LEFT:  key_p1[BIT_LEFT]  <= ps2_key[9];
            SC_P1_RIGHT: key_p1[BIT_RIGHT] <= ps2_key[9];
            SC_P1_B1:    key_p1[BIT_B1]    <= ps2_key[9];
            SC_P1_B2:    key_p1[BIT_B2]    <= ps2_key[9];
            SC_P1_B3:    key_p1[BIT_B3]    <= ps2_key[9];
            SC_P1_START: key_p1[BIT_START] <= ps2_key[9];
            SC_P1_COIN:  key_p1[BIT_COIN]  <= ps2_key[9];
            SC_P1_PAUSE: key_p1[BIT_PAUSE] <= ps2_key[9];
            SC_P2_UP:    key_p2[BIT_UP]    <= ps2_key[9];
            SC_P2_DOWN:  key_p2[BIT_DOWN]  <= ps2_key[9];
            SC_P2_LEFT:  key_p2[BIT_LEFT]  <= ps2_key[9];
            SC_P2_RIGHT: key_p2[BIT_RIGHT] <= ps2_key[9];
            SC_P2_B1:    key_p2[BIT_B1]    <= ps2_key[9];
            SC_P2_B2:    key_p2[BIT_B2]    <= ps2_key[9];
            SC_P2_B3:    key_p2[BIT_B3]    <= ps2_key[9];
            SC_P2_START: key_p2[BIT_START] <= ps2_key[9];
            SC_P2_COIN:  key_p2[BIT_COIN]  <= ps2_key[9];
            SC_SERVICE1: key_svc1          <= ps2_key[9];
            SC_SERVICE2: key_svc2          <= ps2_key[9];
            default: ;
         endcase
      end
   end

   // Frame marker edge detector shared by both coin stretchers.
   always_ff @(posedge clock) begin
      if (reset) vblank_q <= 1'b0;
      else       vblank_q <= vblank;
   end

   assign vblank_rise = vblank & ~vblank_q;

   // Player 2 has no pause key; its pause comes from the joystick alone.
   assign raw_p1 = key_p1 | joy_to_player(joystick_0[9:0]);
   assign raw_p2 = {1'b0, key_p2[8:0]} | joy_to_player(joystick_1[9:0]);

   coin_stretch #(.COIN_FRAMES(COIN_FRAMES)) u_coin_p1 (
      .clock      (clock),
      .reset      (reset),
      .coin       (raw_p1[BIT_COIN]),
      .vblank_rise(vblank_rise),
      .coin_out   (coin_p1)
   );

   coin_stretch #(.COIN_FRAMES(COIN_FRAMES)) u_coin_p2 (
      .clock      (clock),
      .reset      (reset),
      .coin       (raw_p2[BIT_COIN]),
      .vblank_rise(vblank_rise),
      .coin_out   (coin_p2)
   );

   // Substitute the stretched coin into each player word.
   always_comb begin
      // NOTE: every always_comb output gets a full default first so no path can infer a latch.
      cooked_p1           = raw_p1;
      cooked_p2           = raw_p2;
      cooked_p1[BIT_COIN] = coin_p1;
      cooked_p2[BIT_COIN] = coin_p2;
   end

   // Registered outputs with SOCD cleaning applied per player.
   always_ff @(posedge clock) begin
      if (reset) begin
         p1       <= '0;
         p2       <= '0;
         service1 <= 1'b0;
         service2 <= 1'b0;
      end else begin
         p1       <= socd(cooked_p1);
         p2       <= socd(cooked_p2);
         service1 <= key_svc1 | joystick_0[10];
         service2 <= key_svc2 | joystick_1[10];
      end
   end

   assign unused_inputs = ^{joystick_0[31:11], joystick_1[31:11], ps2_key[8]};

endmodule
